// File: rtl/muxn_pipe_if.sv
// Handshake bundle for muxn_pipe: N valid/ready input channels, channel select and
// mode, and one registered valid/ready output carrying data plus source channel index.
interface muxn_pipe_if #(
    parameter int BITWIDTH = 32,
    parameter int CHANNELS = 4,
    parameter int SELW     = 2
);
    logic [CHANNELS-1:0]          in_valid;
    logic [CHANNELS-1:0]          in_ready;
    logic [CHANNELS*BITWIDTH-1:0] in_data;
    logic [SELW-1:0]              sel;
    logic                         sel_mode;
    logic                         out_valid;
    logic                         out_ready;
    logic [BITWIDTH-1:0]          out_data;
    logic [SELW-1:0]              out_chan;

    modport master (
        output in_valid, in_data, sel, sel_mode, out_ready,
        input  in_ready, out_valid, out_data, out_chan
    );

    modport slave (
        input  in_valid, in_data, sel, sel_mode, out_ready,
        output in_ready, out_valid, out_data, out_chan
    );
endinterface

// File: rtl/muxn_pipe.sv
// Registered N-channel mux with a one-entry valid/ready output stage.
// Define MUXN_PIPE_RR_EN to build the round-robin selection mode and its pointer.
module muxn_pipe #(
    parameter int BITWIDTH = 32,
    parameter int CHANNELS = 4,
    parameter int SELW     = 2
) (
    input  logic       clk,
    input  logic       reset,
    muxn_pipe_if.slave bus
);
    logic [CHANNELS-1:0] exp_oh;
    logic [CHANNELS-1:0] gnt_oh;
    logic [SELW-1:0]     idx_term  [CHANNELS];
    logic [BITWIDTH-1:0] data_term [CHANNELS];
    logic [SELW-1:0]     gnt_idx;
    logic [BITWIDTH-1:0] gnt_data;
    logic                can_load;
    logic                in_xfer;
    logic                out_xfer;

    logic                out_valid_q, out_valid_d;
    logic [BITWIDTH-1:0] out_data_q,  out_data_d;
    logic [SELW-1:0]     out_chan_q,  out_chan_d;

`ifdef MUXN_PIPE_RR_EN
    logic [SELW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CHANNELS-1:0] hi_req;
    logic [CHANNELS-1:0] rr_oh;
`endif

    // Per-channel select decode and masked index/data terms of the one-hot grant.
    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            localparam logic [SELW-1:0] IDX = SELW'(gi);
            assign exp_oh[gi]    = (bus.sel == IDX);
            assign idx_term[gi]  = gnt_oh[gi] ? IDX : '0;
            assign data_term[gi] = gnt_oh[gi] ? bus.in_data[gi*BITWIDTH +: BITWIDTH] : '0;
`ifdef MUXN_PIPE_RR_EN
            assign hi_req[gi]    = bus.in_valid[gi] && (IDX > rr_ptr_q);
`endif
        end
    endgenerate

`ifdef MUXN_PIPE_RR_EN
    function automatic logic [CHANNELS-1:0] lowest_set(input logic [CHANNELS-1:0] v);
        return v & (~v + CHANNELS'(1));
    endfunction

    // Channels above the pointer win first; otherwise wrap to the lowest valid one.
    assign rr_oh    = (|hi_req) ? lowest_set(hi_req) : lowest_set(bus.in_valid);
    assign gnt_oh   = bus.sel_mode ? rr_oh : exp_oh;
    assign rr_ptr_d = (in_xfer && bus.sel_mode) ? gnt_idx : rr_ptr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q <= SELW'(CHANNELS - 1);
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    logic unused_sel_mode;
    assign unused_sel_mode = bus.sel_mode;
    assign gnt_oh          = exp_oh;
`endif

    always_comb begin
        gnt_idx  = '0;
        gnt_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            gnt_idx  = gnt_idx | idx_term[i];
            gnt_data = gnt_data | data_term[i];
        end
    end

    assign can_load     = !out_valid_q || bus.out_ready;
    assign bus.in_ready = (reset || !can_load) ? '0 : gnt_oh;
    assign in_xfer      = |(bus.in_valid & bus.in_ready);
    assign out_xfer     = out_valid_q && bus.out_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        if (in_xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = gnt_data;
            out_chan_d  = gnt_idx;
        end else if (out_xfer) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_chan  = out_chan_q;
endmodule
